fetch_sequencer: RTL and testbench

- Instruction-fetch and PC-sequencing stage directly upstream of the main decoder/control unit.
- Fetches one instruction at a time from instruction memory over a req/ack handshake and presents it to decode over a valid/ready handshake.
- Waits for execute to retire the instruction with a taken/target result. This covers beq, the memory-indirect jmem/bmem targets and js. It then advances the PC.
- Exports the PC and PC+4 of the issued instruction for the pctoreg/link path.

---
 rtl/fetch_pkg.sv | 30 +++
 rtl/fetch_prefetch_buf.sv | 62 ++++++
 rtl/fetch_sequencer.sv | 192 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch / PC-sequencing stage.
//   fetch_state_e    : sequencer states (fetch, issue to decode, wait for execute)
//   PC_INC           : sequential PC step
//   RESET_PC_DEFAULT : default PC loaded on reset
//   opcode/funct bit positions and field extractors used by decode-side code
package fetch_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_ISSUE = 2'd1,
    S_EXEC  = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_INC           = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  function automatic logic [5:0] instr_opcode(input logic [31:0] word);
    return word[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [5:0] instr_funct(input logic [31:0] word);
    return word[FUNCT_MSB:FUNCT_LSB];
  endfunction

endpackage

// File: rtl/fetch_prefetch_buf.sv
// Single-entry prefetch buffer holding the word at PC+4 fetched while the
// current instruction executes.
//   clk, rst_n   : clock, asynchronous active-low reset
//   capture      : store rdata and mark the entry valid
//   flush        : invalidate the entry (consumed or redirected); wins over capture
//   drop_set/clr : track a prefetch whose returning data must be discarded
//   valid, word  : buffered entry
//   drop_pending : an abandoned prefetch is still awaiting its ack
module fetch_prefetch_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        capture,
  input  logic [31:0] rdata,
  input  logic        flush,
  input  logic        drop_set,
  input  logic        drop_clr,
  output logic        valid,
  output logic [31:0] word,
  output logic        drop_pending
);

  logic        valid_q, valid_d;
  logic        drop_q, drop_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    word_d  = word_q;
    drop_d  = drop_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (capture) begin
      valid_d = 1'b1;
      word_d  = rdata;
    end
    if (drop_set) begin
      drop_d = 1'b1;
    end else if (drop_clr) begin
      drop_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

  // Word is qualified by valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    word_q <= word_d;
  end

  assign valid        = valid_q;
  assign word         = word_q;
  assign drop_pending = drop_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch and PC-sequencing stage in front of the decoder.
// Fetches one instruction over imem_req/imem_ack, offers it to decode over
// instr_valid/instr_ready, then waits for execute to retire it with a
// taken/target result before advancing the PC.
//   imem_req/imem_addr/imem_ack/imem_rdata : instruction-memory handshake
//   instr_valid/instr/instr_ready          : decode handshake
//   pc_out/pc_plus4                        : PC of the issued instruction and its link value
//   retire_valid/retire_taken/retire_target: execute resolution
//   misalign_err                           : sticky, a redirect target had [1:0]!=0
//   retired_count                          : free-running retire counter (wraps)
// Optional: define FETCH_SEQUENCER_PREFETCH_EN to fetch PC+4 into a one-entry
// buffer while the current instruction executes.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              instr_valid,
  output logic [31:0]       instr,
  input  logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus4,
  input  logic              retire_valid,
  input  logic              retire_taken,
  input  logic [ADDR_W-1:0] retire_target,
  output logic              misalign_err,
  output logic [31:0]       retired_count
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(PC_INC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] fetch_addr_q, fetch_addr_d;
  logic [ADDR_W-1:0] retire_pc;
  logic              imem_req_q, imem_req_d;
  logic              instr_valid_q, instr_valid_d;
  logic [31:0]       instr_q, instr_d;
  logic              misalign_err_q, misalign_err_d;
  logic [31:0]       retired_count_q, retired_count_d;

`ifdef FETCH_SEQUENCER_PREFETCH_EN
  logic        pb_capture, pb_flush, pb_drop_set, pb_drop_clr;
  logic        pb_valid, pb_drop;
  logic [31:0] pb_word;

  fetch_prefetch_buf u_prefetch_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .capture      (pb_capture),
    .rdata        (imem_rdata),
    .flush        (pb_flush),
    .drop_set     (pb_drop_set),
    .drop_clr     (pb_drop_clr),
    .valid        (pb_valid),
    .word         (pb_word),
    .drop_pending (pb_drop)
  );
`endif

  always_comb begin
    state_d         = state_q;
    pc_d            = pc_q;
    fetch_addr_d    = fetch_addr_q;
    imem_req_d      = imem_req_q;
    instr_valid_d   = instr_valid_q;
    instr_d         = instr_q;
    misalign_err_d  = misalign_err_q;
    retired_count_d = retired_count_q;
    retire_pc       = retire_taken ? {retire_target[ADDR_W-1:2], 2'b00} : pc_q + PC_STEP;
`ifdef FETCH_SEQUENCER_PREFETCH_EN
    pb_capture  = 1'b0;
    pb_flush    = 1'b0;
    pb_drop_set = 1'b0;
    pb_drop_clr = 1'b0;
`endif

    case (state_q)
      S_FETCH: begin
        // Request is raised on the first edge in this state and held until ack;
        // an ack with no request outstanding is ignored.
        imem_req_d = 1'b1;
        if (imem_req_q && imem_ack) begin
`ifdef FETCH_SEQUENCER_PREFETCH_EN
          if (pb_drop) begin
            // Stale prefetch completed: discard it and fetch the redirect target.
            pb_drop_clr  = 1'b1;
            fetch_addr_d = pc_q;
          end else
`endif
          begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = S_ISSUE;
          end
        end
      end

      S_ISSUE: begin
        if (instr_ready) begin
          instr_valid_d = 1'b0;
          state_d       = S_EXEC;
        end
      end

      S_EXEC: begin
`ifdef FETCH_SEQUENCER_PREFETCH_EN
        if (!imem_req_q && !pb_valid) begin
          imem_req_d   = 1'b1;
          fetch_addr_d = pc_q + PC_STEP;
        end else if (imem_req_q && imem_ack) begin
          imem_req_d = 1'b0;
          pb_capture = 1'b1;
        end
`endif
        if (retire_valid) begin
          pc_d            = retire_pc;
          retired_count_d = retired_count_q + 32'd1;
          if (retire_taken && (retire_target[1:0] != 2'b00)) begin
            misalign_err_d = 1'b1;
          end
          state_d      = S_FETCH;
          imem_req_d   = 1'b1;
          fetch_addr_d = retire_pc;
`ifdef FETCH_SEQUENCER_PREFETCH_EN
          pb_capture = 1'b0;
          pb_flush   = 1'b1;
          if (!retire_taken && pb_valid) begin
            instr_d       = pb_word;
            instr_valid_d = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = S_ISSUE;
          end else if (!retire_taken && imem_req_q && imem_ack) begin
            instr_d       = imem_rdata;
            instr_valid_d = 1'b1;
            imem_req_d    = 1'b0;
            state_d       = S_ISSUE;
          end else if (retire_taken && imem_req_q && !imem_ack) begin
            // Prefetch still in flight: keep its address stable until the ack.
            pb_drop_set  = 1'b1;
            fetch_addr_d = fetch_addr_q;
          end
          // A not-taken retire with the prefetch in flight keeps the request;
          // its address already equals the new PC.
`endif
        end
      end

      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_FETCH;
      pc_q            <= RESET_PC;
      fetch_addr_q    <= RESET_PC;
      imem_req_q      <= 1'b0;
      instr_valid_q   <= 1'b0;
      instr_q         <= 32'd0;
      misalign_err_q  <= 1'b0;
      retired_count_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      pc_q            <= pc_d;
      fetch_addr_q    <= fetch_addr_d;
      imem_req_q      <= imem_req_d;
      instr_valid_q   <= instr_valid_d;
      instr_q         <= instr_d;
      misalign_err_q  <= misalign_err_d;
      retired_count_q <= retired_count_d;
    end
  end

  assign imem_req      = imem_req_q;
  assign imem_addr     = fetch_addr_q;
  assign instr_valid   = instr_valid_q;
  assign instr         = instr_q;
  assign pc_out        = pc_q;
  assign pc_plus4      = pc_q + PC_STEP;
  assign misalign_err  = misalign_err_q;
  assign retired_count = retired_count_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: bench-side instruction memory,
// decode and execute agents, and an architectural model (PC, retire count,
// sticky misalign flag) compared against the DUT every cycle.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        retire_valid;
  logic        retire_taken;
  logic [31:0] retire_target;
  logic        misalign_err;
  logic [31:0] retired_count;

  always #5 clk = ~clk;

  fetch_sequencer #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr         (instr),
    .instr_ready   (instr_ready),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .retire_valid  (retire_valid),
    .retire_taken  (retire_taken),
    .retire_target (retire_target),
    .misalign_err  (misalign_err),
    .retired_count (retired_count)
  );

  int errors = 0;
  int checks = 0;

  // Architectural model
  logic [31:0] m_pc;
  logic [31:0] m_cnt;
  logic        m_mis;
  bit          outstanding;
  int          retired;

  // Agent knobs
  int          ack_dly;        // <0: random 0..3 cycles
  int          spur_ack_mode;  // 0 none, 1 random, 2 every idle cycle
  int          rdy_mode;       // 0 never, 1 always, 2 random
  int          ret_dly_max;
  int          spur_ret;       // 0 none, 1 random, 2 always
  int          br_mode;        // 0 not taken, 1 taken to nx_target, 2 random
  logic [31:0] nx_target;
  bit          cmp_en;

  bit          prev_valid;
  int          ret_wait;
  logic [31:0] acked[$];
  int          gap;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h8C01_0004;
  endfunction

  function automatic logic [31:0] acked_at(input int i);
    if (i < acked.size()) return acked[i];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Instruction memory agent
  initial begin : imem_agent
    int wait_cnt;
    int rnd_dly;
    int d;
    wait_cnt   = 0;
    rnd_dly    = 0;
    imem_ack   = 1'b0;
    imem_rdata = 32'd0;
    forever begin
      @(posedge clk);
      #2;
      imem_ack   = 1'b0;
      imem_rdata = $urandom;
      d = (ack_dly < 0) ? rnd_dly : ack_dly;
      if (!rst_n) begin
        wait_cnt = 0;
        if (spur_ack_mode == 2) imem_ack = 1'b1;
      end else if (imem_req) begin
        if (wait_cnt >= d) begin
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          acked.push_back(imem_addr);
          wait_cnt = 0;
          rnd_dly  = $urandom_range(0, 3);
        end else begin
          wait_cnt++;
        end
      end else if (spur_ack_mode == 2 || (spur_ack_mode == 1 && $urandom_range(0, 3) == 0)) begin
        imem_ack = 1'b1;
      end
    end
  end

  // Per-cycle comparison against the model
  initial begin : compare
    int  cyc;
    int  last_rise;
    bit  last_v;
    cyc = 0; last_rise = 0; last_v = 1'b0; gap = 0;
    forever begin
      @(posedge clk);
      #5;
      cyc++;
      if (rst_n && cmp_en) begin
        check32("retired_count", retired_count, m_cnt);
        check32("misalign_err", {31'd0, misalign_err}, {31'd0, m_mis});
        if (outstanding) check32("valid_during_exec", {31'd0, instr_valid}, 32'd0);
        if (instr_valid) begin
          check32("instr", instr, mem_word(m_pc));
          check32("pc_out", pc_out, m_pc);
          check32("pc_plus4", pc_plus4, m_pc + 32'd4);
        end
`ifndef FETCH_SEQUENCER_PREFETCH_EN
        if (imem_req) check32("imem_addr", imem_addr, m_pc);
        if (outstanding) check32("req_during_exec", {31'd0, imem_req}, 32'd0);
`endif
        if (instr_valid && !last_v) begin
          gap       = cyc - last_rise;
          last_rise = cyc;
        end
      end
      last_v = instr_valid;
    end
  end

  // One clock of the decode/execute agent: account for what the DUT consumed
  // at this edge, then choose the inputs for the coming cycle.
  task automatic cycle();
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (retire_valid && outstanding) begin
        m_cnt = m_cnt + 32'd1;
        if (retire_taken) begin
          if (retire_target[1:0] != 2'b00) m_mis = 1'b1;
          m_pc = retire_target & 32'hFFFF_FFFC;
        end else begin
          m_pc = m_pc + 32'd4;
        end
        outstanding = 1'b0;
        retired++;
      end
      if (prev_valid && instr_ready) begin
        outstanding = 1'b1;
        ret_wait    = (ret_dly_max == 0) ? 0 : int'($urandom_range(0, ret_dly_max));
      end
    end
    prev_valid    = instr_valid;
    instr_ready   = (rdy_mode == 1) || (rdy_mode == 2 && $urandom_range(0, 2) == 0);
    retire_valid  = 1'b0;
    retire_taken  = 1'($urandom);
    retire_target = $urandom;
    if (outstanding) begin
      if (ret_wait == 0) begin
        retire_valid = 1'b1;
        if (br_mode == 0) begin
          retire_taken = 1'b0;
        end else if (br_mode == 1) begin
          retire_taken  = 1'b1;
          retire_target = nx_target;
        end else begin
          retire_taken  = ($urandom_range(0, 2) == 0);
          retire_target = 32'($urandom_range(0, 255)) << 2;
          if ($urandom_range(0, 15) == 0) retire_target[1:0] = 2'($urandom_range(1, 3));
          if ($urandom_range(0, 31) == 0) retire_target = 32'hFFFF_FFFC;
        end
      end else begin
        ret_wait--;
      end
    end else if (spur_ret == 2 || (spur_ret == 1 && $urandom_range(0, 1) == 0)) begin
      retire_valid = 1'b1;
    end
  endtask

  task automatic wait_valid(input int budget);
    int n;
    rdy_mode = 0;
    n = 0;
    do begin
      cycle();
      n++;
    end while (!instr_valid && n < budget);
    if (!instr_valid) begin
      checks++; errors++;
      $display("FAIL wait_valid: no instr_valid within %0d cycles", budget);
    end
  endtask

  task automatic run_retires(input int n, input int budget);
    int target;
    int c;
    target   = retired + n;
    rdy_mode = (rdy_mode == 0) ? 1 : rdy_mode;
    c = 0;
    while (retired < target && c < budget) begin
      cycle();
      c++;
    end
    if (retired < target) begin
      checks++; errors++;
      $display("FAIL run_retires: %0d of %0d retires within %0d cycles", retired - (target - n), n, budget);
    end
  endtask

  task automatic model_reset();
    m_pc        = 32'h0000_0000;
    m_cnt       = 32'd0;
    m_mis       = 1'b0;
    outstanding = 1'b0;
    prev_valid  = 1'b0;
    ret_wait    = 0;
  endtask

  initial begin : main
    logic [31:0] hold_instr;
    logic [31:0] hold_pc;
    int          base;

    ack_dly = 1; spur_ack_mode = 0; rdy_mode = 0; ret_dly_max = 0;
    spur_ret = 0; br_mode = 0; nx_target = 32'd0; cmp_en = 1'b0; retired = 0;
    instr_ready = 1'b0; retire_valid = 1'b0; retire_taken = 1'b0; retire_target = 32'd0;
    model_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check32("rst_imem_req", {31'd0, imem_req}, 32'd0);
    check32("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check32("rst_instr", instr, 32'd0);
    check32("rst_pc_out", pc_out, 32'h0000_0000);
    check32("rst_pc_plus4", pc_plus4, 32'h0000_0004);
    check32("rst_misalign", {31'd0, misalign_err}, 32'd0);
    check32("rst_count", retired_count, 32'd0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // First fetch: request on the first edge, ack on the second request cycle
    cycle();
    check32("first_req", {31'd0, imem_req}, 32'd1);
    check32("first_addr", imem_addr, 32'h0000_0000);
    wait_valid(20);
    check32("first_acked_addr", acked_at(0), 32'h0000_0000);
    check32("first_instr", instr, 32'h8C01_0004);
    check32("first_opcode", {26'd0, instr_opcode(instr)}, 32'h0000_0023);
    check32("first_funct", {26'd0, instr_funct(instr)}, 32'h0000_0004);
    check32("first_pc_out", pc_out, 32'h0000_0000);
    check32("first_pc_plus4", pc_plus4, 32'h0000_0004);

    // Three not-taken retires
    ack_dly = 0; br_mode = 0; ret_dly_max = 0;
    run_retires(3, 60);
    check32("count_after_3", retired_count, 32'd3);
    wait_valid(20);
    check32("seq_addr1", acked_at(1), 32'h0000_0004);
    check32("seq_addr2", acked_at(2), 32'h0000_0008);
    check32("seq_addr3", acked_at(3), 32'h0000_000C);
    check32("seq_pc_out", pc_out, 32'h0000_000C);

    // Taken redirect (jmem) to 0x100
    br_mode = 1; nx_target = 32'h0000_0100;
    run_retires(1, 40);
    wait_valid(20);
    check32("jmem_addr", acked[$], 32'h0000_0100);
    check32("jmem_pc_plus4", pc_plus4, 32'h0000_0104);
    check32("jmem_misalign", {31'd0, misalign_err}, 32'd0);

    // Misaligned redirect target
    nx_target = 32'h0000_0102;
    run_retires(1, 40);
    wait_valid(20);
    check32("mis_addr", acked[$], 32'h0000_0100);
    check32("mis_flag", {31'd0, misalign_err}, 32'd1);

    // Decode stall with spurious retire and ack while the instruction is offered
    spur_ret = 2; spur_ack_mode = 2;
    hold_instr = instr;
    hold_pc    = pc_out;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check32("stall_valid", {31'd0, instr_valid}, 32'd1);
      check32("stall_instr", instr, hold_instr);
      check32("stall_pc", pc_out, hold_pc);
    end
    spur_ret = 0; spur_ack_mode = 0; br_mode = 0;
    run_retires(2, 60);
    check32("mis_sticky", {31'd0, misalign_err}, 32'd1);

    // Reset while a fetch is waiting for its ack; acks arrive during and after reset
    ack_dly = 5;
    wait_valid(30);
    run_retires(1, 40);
    cycle();
    check32("pre_rst_req", {31'd0, imem_req}, 32'd1);
    spur_ack_mode = 2;
    rst_n = 1'b0;
    #1;
    check32("midrst_req", {31'd0, imem_req}, 32'd0);
    check32("midrst_valid", {31'd0, instr_valid}, 32'd0);
    check32("midrst_pc", pc_out, 32'h0000_0000);
    check32("midrst_mis", {31'd0, misalign_err}, 32'd0);
    check32("midrst_count", retired_count, 32'd0);
    model_reset();
    instr_ready = 1'b0; retire_valid = 1'b0;
    acked.delete();
    cycle();
    rst_n   = 1'b1;
    ack_dly = 2;
    wait_valid(20);
    spur_ack_mode = 0;
    check32("refetch_addr", acked_at(0), 32'h0000_0000);
    check32("refetch_instr", instr, 32'h8C01_0004);
    check32("refetch_pc", pc_out, 32'h0000_0000);

    // Randomized traffic
    ack_dly = -1; spur_ack_mode = 1; rdy_mode = 2; ret_dly_max = 4;
    spur_ret = 1; br_mode = 2;
    run_retires(300, 30000);

    // Back-to-back minimum latency
    spur_ack_mode = 0; spur_ret = 0; ack_dly = 0; ret_dly_max = 0; br_mode = 0;
    rdy_mode = 1;
    run_retires(5, 100);
    check32("min_latency", 32'(gap), 32'd3);

    // PC+4 wraps at the top of the address space
    wait_valid(20);
    br_mode = 1; nx_target = 32'hFFFF_FFFC;
    run_retires(1, 40);
    wait_valid(20);
    check32("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check32("wrap_pc_plus4", pc_plus4, 32'h0000_0000);
    br_mode = 0;
    base = retired;
    run_retires(1, 40);
    wait_valid(20);
    check32("wrap_next_pc", pc_out, 32'h0000_0000);
    check32("wrap_next_instr", instr, 32'h8C01_0004);
    check32("wrap_retires", 32'(retired - base), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
